// File: rtl/alu_pkg.sv
// Shared opcode map and flag bundle for the two-stage ALU pipeline.
// Overflow/carry flags are only driven when built with ALU_OVF_EN.
package alu_pkg;

  localparam logic [2:0] ALU_NOP   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_NEG   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_PASSA = 3'b111;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } alu_flags_t;

  localparam alu_flags_t ALU_FLAGS_CLR = '0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: opcode/a/b -> result and Z/N flags.
// With ALU_OVF_EN the V/C flags are computed; otherwise they are tied low.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

`ifdef ALU_OVF_EN
  localparam int XW = WIDTH + 1;
`else
  localparam int XW = WIDTH;
`endif

  logic [XW-1:0]    sum;
  logic [XW-1:0]    diff;
  logic [WIDTH-1:0] neg;

  assign sum  = XW'(a) + XW'(b);
  assign diff = XW'(a) - XW'(b);
  assign neg  = {WIDTH{1'b0}} - a;

  always_comb begin
    result = '0;
    flags  = ALU_FLAGS_CLR;
    case (opcode)
      ALU_SUB:   result = diff[WIDTH-1:0];
      ALU_NEG:   result = neg;
      ALU_AND:   result = a & b;
      ALU_ADD:   result = sum[WIDTH-1:0];
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_PASSA: result = a;
      default:   result = '0;
    endcase
    flags.z = (result == '0);
    flags.n = result[WIDTH-1];
`ifdef ALU_OVF_EN
    // carry/borrow come from the extra top bit of the widened add/sub
    case (opcode)
      ALU_ADD: begin
        flags.c = sum[WIDTH];
        flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        flags.c = diff[WIDTH];
        flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_NEG: begin
        flags.c = |a;
        flags.v = a[WIDTH-1] && result[WIDTH-1];
      end
      default: begin
        flags.c = 1'b0;
        flags.v = 1'b0;
      end
    endcase
`endif
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides; NOPs re-emit the last result.
// Optional ALU_OVF_EN adds the V/C overflow/carry outputs.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N
`ifdef ALU_OVF_EN
  ,
  output logic             V,
  output logic             C
`endif
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flg_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_res),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= ALU_NOP;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= opcode;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  // res_q/flg_q double as the last-result register: a NOP leaves them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      flg_q    <= ALU_FLAGS_CLR;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid && (s1_op != ALU_NOP)) begin
        res_q <= core_res;
        flg_q <= core_flags;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out       = res_q;
  assign Z         = flg_q.z;
  assign N         = flg_q.n;

`ifdef ALU_OVF_EN
  assign V = flg_q.v;
  assign C = flg_q.c;
`else
  logic unused_ovf;
  assign unused_ovf = flg_q.v ^ flg_q.c;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results queued at input handshake, compared at output handshake.
// Define ALU_OVF_EN to also exercise the V/C flags.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         Z;
  logic         N;
  logic         V;
  logic         C;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .Z         (Z),
    .N         (N)
`ifdef ALU_OVF_EN
    ,
    .V         (V),
    .C         (C)
`endif
  );

`ifndef ALU_OVF_EN
  assign V = 1'b0;
  assign C = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         v;
    logic         c;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         sbq[$];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           lat_on = 1'b1;
  bit           stalled = 1'b0;
  logic [W-1:0] hold_out;
  logic         hold_z;
  logic         hold_n;
  logic [W-1:0] m_res = '0;
  logic         m_z = 1'b0;
  logic         m_n = 1'b0;
  logic         m_v = 1'b0;
  logic         m_c = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         v;
    logic         c;
    v = 1'b0;
    c = 1'b0;
    r = '0;
    t = '0;
    if (op != ALU_NOP) begin
      case (op)
        ALU_ADD: begin
          t = {1'b0, x} + {1'b0, y};
          r = t[W-1:0];
          c = t[W];
          v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        ALU_SUB: begin
          r = x - y;
          c = (x < y);
          v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        ALU_NEG: begin
          r = ~x + 1'b1;
          c = (x != '0);
          v = (x == {1'b1, {(W-1){1'b0}}});
        end
        ALU_AND: r = x & y;
        ALU_OR:  r = x | y;
        ALU_XOR: r = x ^ y;
        default: r = x;
      endcase
      m_res = r;
      m_z   = (r == '0);
      m_n   = r[W-1];
      m_v   = v;
      m_c   = c;
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (out_valid && !out_ready) begin
        if (stalled) begin
          check("stall_out", out, hold_out);
          check("stall_z", Z, hold_z);
          check("stall_n", N, hold_n);
        end
        stalled  = 1'b1;
        hold_out = out;
        hold_z   = Z;
        hold_n   = N;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out", out, e.res);
          check("Z", Z, e.z);
          check("N", N, e.n);
`ifdef ALU_OVF_EN
          check("V", V, e.v);
          check("C", C, e.c);
`endif
          if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        model(opcode, a, b);
        e.res = m_res;
        e.z   = m_z;
        e.n   = m_n;
        e.v   = m_v;
        e.c   = m_c;
        e.cyc = cyc;
        e.lat = lat_on;
        sbq.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) check("send_timeout_in_ready", in_ready, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    while (sbq.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  task automatic flush_model();
    sbq.delete();
    m_res   = '0;
    m_z     = 1'b0;
    m_n     = 1'b0;
    m_v     = 1'b0;
    m_c     = 1'b0;
    stalled = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, pending=%0d", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = ALU_NOP;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_Z", Z, 1'b0);
    check("rst_N", N, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // basic arithmetic, full throughput
    send(ALU_ADD, 6, 5);
    send(ALU_SUB, 6, 5);
    send(ALU_NEG, 6, 5);
    send(ALU_PASSA, 6, 5);
    drain();

    // zero result, then NOP re-emits it
    send(ALU_SUB, 6, 6);
    send(ALU_NOP, 32'h1234, 32'h5678);
    drain();

    send(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    send(ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00);
    send(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00);
    send(ALU_NOP, 0, 0);
    drain();

    // in_ready stays high with only one stage occupied
    lat_on    = 1'b0;
    out_ready = 1'b0;
    send(ALU_ADD, 1, 2);
    idle(2);
    check("ready_one_stalled", in_ready, 1'b1);
    send(ALU_ADD, 3, 4);
    check("ready_both_stalled", in_ready, 1'b0);
    idle(3);
    out_ready = 1'b1;
    drain();

    // 8 back-to-back ADDs with a 4-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(ALU_ADD, 32'(i * 10), 32'(i + 1));
        in_valid = 1'b0;
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        check("ready_during_stall", in_ready, 1'b0);
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    lat_on = 1'b1;

    // reset with two ops in flight
    send(ALU_ADD, 3, 4);
    send(ALU_SUB, 9, 2);
    in_valid = 1'b0;
    rst = 1'b1;
    flush_model();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out", out, '0);
    check("midrst_Z", Z, 1'b0);
    check("midrst_N", N, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_out_valid_edge", out_valid, 1'b0);
    rst = 1'b0;
    send(ALU_ADD, 1, 1);
    drain();

`ifdef ALU_OVF_EN
    send(ALU_ADD, 32'h7FFFFFFF, 1);
    send(ALU_ADD, 32'hFFFFFFFF, 1);
    send(ALU_SUB, 0, 1);
    send(ALU_NEG, 0, 0);
    send(ALU_NEG, 32'h80000000, 0);
    send(ALU_XOR, 32'hFFFFFFFF, 1);
    send(ALU_NOP, 0, 0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
